code_seq_detector: RTL

//   Downstream consumer of the 3-bit per-cycle status code stream (HI=3'b010, LO=3'b011).

---
 rtl/code_seq_detector_pkg.sv | 10 +
 rtl/code_seq_detector_if.sv | 27 ++
 rtl/code_seq_detector_sat_counter.sv | 21 ++
 rtl/code_seq_detector.sv | 77 +++++++
 4 files changed

// File: rtl/code_seq_detector_pkg.sv
// code_seq_detector_pkg: shared code values and FSM state encoding
// Used by: code_seq_detector, code_seq_detector_if users
//   state_t      : S0..S3 progress through the LO,LO,HI,HI pattern
//   CODE_HI_DEF  : default code treated as HI
//   CODE_LO_DEF  : default code treated as LO
package code_seq_detector_pkg;
    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;
    localparam logic [2:0] CODE_HI_DEF = 3'b010;
    localparam logic [2:0] CODE_LO_DEF = 3'b011;
endpackage

// File: rtl/code_seq_detector_if.sv
// code_seq_detector_if: status code stream in, run/match status out
// Optional feature macro: CODE_SEQ_MATCH_CNT_EN (adds match_cnt)
// Signals:
//   in_valid  : code qualifier
//   code      : 3-bit status code
//   run_code  : last accepted legal code
//   run_len   : saturating run length of run_code
//   match     : LO,LO,HI,HI completed pulse
//   bad_code  : illegal accepted code pulse
//   match_cnt : saturating match count (optional)
// Modports: master drives the code stream, slave is the detector
interface code_seq_detector_if #(parameter int CNT_W = 8);
    logic             in_valid;
    logic [2:0]       code;
    logic [2:0]       run_code;
    logic [CNT_W-1:0] run_len;
    logic             match;
    logic             bad_code;
`ifdef CODE_SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
    modport master (output in_valid, code, input run_code, run_len, match, bad_code, match_cnt);
    modport slave (input in_valid, code, output run_code, run_len, match, bad_code, match_cnt);
`else
    modport master (output in_valid, code, input run_code, run_len, match, bad_code);
    modport slave (input in_valid, code, output run_code, run_len, match, bad_code);
`endif
endinterface

// File: rtl/code_seq_detector_sat_counter.sv
// sat_counter: saturating up-counter with clear and load-to-one
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset to 0
//   clr   : clear to 0 (below reset)
//   inc   : increment, holds at all-ones
//   load1 : load 1 (beats inc)
//   q     : count
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         load1,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= (reset || clr) ? '0 :
             load1 ? W'(1) :
             (inc && q != '1) ? q + 1'b1 : q;
endmodule

// File: rtl/code_seq_detector.sv
// code_seq_detector: run-length tracker and LO,LO,HI,HI detector for a status code stream
// Optional feature macro: CODE_SEQ_MATCH_CNT_EN (saturating match counter on bus.match_cnt)
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : code_seq_detector_if.slave (in_valid, code in; run_code, run_len, match, bad_code out)
// Parameters: CNT_W counter width, CODE_HI / CODE_LO code values
module code_seq_detector
    import code_seq_detector_pkg::*;
#(
    parameter int         CNT_W   = 8,
    parameter logic [2:0] CODE_HI = CODE_HI_DEF,
    parameter logic [2:0] CODE_LO = CODE_LO_DEF
) (
    input logic                 clk,
    input logic                 reset,
    code_seq_detector_if.slave  bus
);
    state_t           state_q, state_d;
    logic [2:0]       run_code_q;
    logic [CNT_W-1:0] run_len_q;
    logic             match_q, match_d, bad_q, bad_d;
    logic             is_hi, is_lo, legal, same_run;
    assign is_hi    = bus.code == CODE_HI;
    assign is_lo    = bus.code == CODE_LO;
    assign legal    = is_hi || is_lo;
    // run_len==0 means no current run, so a matching code still restarts at 1
    assign same_run = bus.code == run_code_q && run_len_q != '0;
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        bad_d   = 1'b0;
        if (bus.in_valid && !legal) begin
            state_d = S0;
            bad_d   = 1'b1;
        end else if (bus.in_valid) begin
            unique case (state_q)
                S0: state_d = is_lo ? S1 : S0;
                S1: state_d = is_lo ? S2 : S0;
                S2: state_d = is_lo ? S2 : S3;
                S3: begin
                    state_d = is_lo ? S1 : S0;
                    match_d = is_hi;
                end
                default: state_d = S0;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        state_q    <= reset ? S0 : state_d;
        match_q    <= !reset && match_d;
        bad_q      <= !reset && bad_d;
        run_code_q <= reset ? 3'b000 : !bus.in_valid ? run_code_q : legal ? bus.code : 3'b000;
    end
    sat_counter #(.W(CNT_W)) u_run_len (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.in_valid && !legal),
        .inc   (bus.in_valid && legal && same_run),
        .load1 (bus.in_valid && legal && !same_run),
        .q     (run_len_q)
    );
`ifdef CODE_SEQ_MATCH_CNT_EN
    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (match_d),
        .load1 (1'b0),
        .q     (bus.match_cnt)
    );
`endif
    assign bus.run_code = run_code_q;
    assign bus.run_len  = run_len_q;
    assign bus.match    = match_q;
    assign bus.bad_code = bad_q;
endmodule
